// File: rtl/gpr_write_controller.sv
// -----------------------------------------------------------------------------
// gpr_write_controller
//
// Sits in front of the general purpose register file, which has a single write
// port and no reset of its own. Out of reset it sweeps zeros into registers
// 1 .. 2**ADDRESS_SIZE-1. It then shares the write port between NUM_REQ
// writeback requesters with round-robin arbitration over valid/ready. It also
// forwards the in-flight write onto both read ports (write-through bypass).
//
// Ports:
//   system_clock, system_reset_n       clock, async active-low reset
//   req_valid/req_address/req_data     packed per-requester write requests
//   req_ready                          one-hot grant (transfer = valid & ready)
//   init_done                          zero sweep complete
//   write_enable/address/data          registered register-file write port
//   read_address_1/2                   read addresses shared with the regfile
//   gpr_read_data_1/2                  raw register-file read data
//   read_data_1/2                      bypassed read data to the datapath
// -----------------------------------------------------------------------------
module gpr_write_controller #(
    parameter int NUM_REQ      = 3,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_SIZE = 5
) (
    input  logic                            system_clock,
    input  logic                            system_reset_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*ADDRESS_SIZE-1:0] req_address,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            init_done,
    output logic                            write_enable,
    output logic [ADDRESS_SIZE-1:0]         write_address,
    output logic [DATA_WIDTH-1:0]           write_data,
    input  logic [ADDRESS_SIZE-1:0]         read_address_1,
    input  logic [ADDRESS_SIZE-1:0]         read_address_2,
    input  logic [DATA_WIDTH-1:0]           gpr_read_data_1,
    input  logic [DATA_WIDTH-1:0]           gpr_read_data_2,
    output logic [DATA_WIDTH-1:0]           read_data_1,
    output logic [DATA_WIDTH-1:0]           read_data_2
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                  r_state;
    logic [ADDRESS_SIZE-1:0] r_sweep_count;
    logic [PTR_W-1:0]        r_rr_ptr;
    logic                    r_write_enable;
    logic [ADDRESS_SIZE-1:0] r_write_address;
    logic [DATA_WIDTH-1:0]   r_write_data;
    logic                    r_init_done;

    logic [NUM_REQ-1:0]      w_grant;
    logic [PTR_W-1:0]        w_grant_idx;
    logic                    w_grant_found;
    logic [ADDRESS_SIZE-1:0] w_sel_address;
    logic [DATA_WIDTH-1:0]   w_sel_data;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        int v_idx;
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        w_grant       = '0;
        w_grant_idx   = r_rr_ptr;
        w_grant_found = 1'b0;
        v_idx         = 0;
        if (r_state == ST_RUN) begin
            for (int off = 1; off <= NUM_REQ; off++) begin
                v_idx = (int'(r_rr_ptr) + off) % NUM_REQ;
                if (!w_grant_found && req_valid[v_idx]) begin
                    w_grant_found  = 1'b1;
                    w_grant[v_idx] = 1'b1;
                    w_grant_idx    = PTR_W'(v_idx);
                end
            end
        end
    end

    // One-hot mux of the granted requester's address and data.
    always_comb begin
        w_sel_address = '0;
        w_sel_data    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_address = req_address[i*ADDRESS_SIZE +: ADDRESS_SIZE];
                w_sel_data    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // The register file itself has no reset, so correctness after reset relies
    // on the zero sweep below rather than on resetting any storage array.
    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            r_state         <= ST_INIT;
            r_sweep_count   <= ADDRESS_SIZE'(1);
            r_rr_ptr        <= PTR_W'(NUM_REQ - 1);
            r_write_enable  <= 1'b0;
            r_write_address <= '0;
            r_write_data    <= '0;
            r_init_done     <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            case (r_state)
                ST_INIT: begin
                    r_write_enable  <= 1'b1;
                    r_write_address <= r_sweep_count;
                    r_write_data    <= '0;
                    r_sweep_count   <= r_sweep_count + 1'b1;
                    if (r_sweep_count == {ADDRESS_SIZE{1'b1}}) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_grant_found) begin
                        r_rr_ptr        <= w_grant_idx;
                        // Register 0 is hardwired to zero: accept, never write.
                        r_write_enable  <= (w_sel_address != '0);
                        r_write_address <= w_sel_address;
                        r_write_data    <= w_sel_data;
                    end else begin
                        r_write_enable  <= 1'b0;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    // Write-through bypass: the write registered this cycle commits at its end,
    // so a same-cycle read must see the new value instead of the stale one.
    function automatic logic [DATA_WIDTH-1:0] bypass(
        input logic [ADDRESS_SIZE-1:0] rd_addr,
        input logic [DATA_WIDTH-1:0]   rd_raw
    );
        if (!r_init_done || rd_addr == '0)
            return '0;
        else if (r_write_enable && r_write_address == rd_addr)
            return r_write_data;
        else
            return rd_raw;
    endfunction

    assign req_ready     = w_grant;
    assign init_done     = r_init_done;
    assign write_enable  = r_write_enable;
    assign write_address = r_write_address;
    assign write_data    = r_write_data;
    assign read_data_1   = bypass(read_address_1, gpr_read_data_1);
    assign read_data_2   = bypass(read_address_2, gpr_read_data_2);

endmodule
